// File: rtl/PARAMS_BN254_d0.sv
// Shared constants and types for the BN254 post-adder: limb layout, redundant
// polynomial formats, modulus and lane mode encodings.
package PARAMS_BN254_d0;

    localparam int unsigned ADD_DIV  = 4;
    localparam int unsigned LIMB_W   = 68;
    localparam int unsigned L3_CARRY = 8;
    localparam int unsigned L3_W     = L3_CARRY + LIMB_W;

    typedef logic [LIMB_W-1:0]         fp_div4_t;
    typedef logic [ADD_DIV*LIMB_W-1:0] uint_fp_t;

    // BN254 base-field prime
    localparam uint_fp_t Mod =
        272'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    // Input limb: one unsigned carry bit above the 68-bit value
    typedef struct packed {
        logic     carry;
        fp_div4_t val;
    } limb_l1_t;

    // Accumulator limb: 8-bit two's complement carry above the 68-bit value
    typedef struct packed {
        logic signed [L3_CARRY-1:0] carry;
        fp_div4_t                   val;
    } limb_l3_t;

    typedef limb_l1_t [ADD_DIV-1:0] redundant_poly_L1;
    typedef limb_l3_t [ADD_DIV-1:0] redundant_poly_L3;

    localparam logic [2:0] MODE_R       = 3'b000;
    localparam logic [2:0] MODE_DIN     = 3'b001;
    localparam logic [2:0] MODE_ADD     = 3'b010;
    localparam logic [2:0] MODE_DIN_M_R = 3'b011;
    localparam logic [2:0] MODE_R_M_DIN = 3'b100;
    localparam logic [2:0] MODE_MOD_M_R = 3'b101;
    localparam logic [2:0] MODE_MOD_M_D = 3'b110;
    localparam logic [2:0] MODE_ZERO    = 3'b111;

endpackage

// File: rtl/postadder_lane.sv
// One post-adder lane: mode decode and limb-wise add/subtract, purely
// combinational. Limbs are independent; no carry moves between limbs.
module postadder_lane
    import PARAMS_BN254_d0::*;
(
    input  logic [2:0]       mode,
    input  redundant_poly_L1 din,
    input  redundant_poly_L3 r,
    output redundant_poly_L3 acc_out
);

    // Per-limb arithmetic in 76 bits; wrap-around matches the signed carry field
    always_comb begin
        acc_out = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            logic [L3_W-1:0] r_ext;
            logic [L3_W-1:0] d_ext;
            logic [L3_W-1:0] m_ext;
            logic [L3_W-1:0] sum;
            r_ext = r[i];
            d_ext = L3_W'({din[i].carry, din[i].val});
            m_ext = L3_W'(Mod[i*LIMB_W +: LIMB_W]);
            case (mode)
                MODE_R:       sum = r_ext;
                MODE_DIN:     sum = d_ext;
                MODE_ADD:     sum = d_ext + r_ext;
                MODE_DIN_M_R: sum = d_ext - r_ext;
                MODE_R_M_DIN: sum = r_ext - d_ext;
                MODE_MOD_M_R: sum = m_ext - r_ext;
                MODE_MOD_M_D: sum = m_ext - d_ext;
                default:      sum = '0;
            endcase
            acc_out[i] = sum;
        end
    end

endmodule

// File: rtl/postadder.sv
// Three-lane redundant-form post-adder with a single accumulator for lane 1
// and 4-entry register files for lanes 2 and 3.
module postadder
    import PARAMS_BN254_d0::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  redundant_poly_L1 in_L1,
    input  logic [2:0]       mode1,
    input  logic [2:0]       mode2,
    input  logic [2:0]       mode3,
    input  logic [1:0]       addr2,
    input  logic [1:0]       addr3,
    input  logic [1:0]       outsel,
    output redundant_poly_L3 dout
);

    redundant_poly_L3 reg1;
    redundant_poly_L3 reg2 [4];
    redundant_poly_L3 reg3 [4];
    redundant_poly_L3 acc1_out;
    redundant_poly_L3 acc2_out;
    redundant_poly_L3 acc3_out;

    postadder_lane u_lane1 (
        .mode    (mode1),
        .din     (in_L1),
        .r       (reg1),
        .acc_out (acc1_out)
    );

    postadder_lane u_lane2 (
        .mode    (mode2),
        .din     (in_L1),
        .r       (reg2[addr2]),
        .acc_out (acc2_out)
    );

    postadder_lane u_lane3 (
        .mode    (mode3),
        .din     (in_L1),
        .r       (reg3[addr3]),
        .acc_out (acc3_out)
    );

    // Accumulator write-back; only the addressed file entry is updated
    always_ff @(posedge clk) begin
        if (!rstn) begin
            reg1 <= '0;
            for (int k = 0; k < 4; k++) begin
                reg2[k] <= '0;
                reg3[k] <= '0;
            end
        end else begin
            reg1        <= acc1_out;
            reg2[addr2] <= acc2_out;
            reg3[addr3] <= acc3_out;
        end
    end

    // Output lane select
    always_comb begin
        dout = '0;
        unique case (outsel)
            2'b00:   dout = acc1_out;
            2'b01:   dout = acc2_out;
            2'b10:   dout = acc3_out;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_postadder.sv
// Self-checking bench for postadder: directed lane-1 cases, a scoreboarded
// random run on lanes 2/3 against an integer model, and an outsel sweep.
module tb_postadder;
    import PARAMS_BN254_d0::*;

    logic             clk;
    logic             rstn;
    redundant_poly_L1 din;
    logic [2:0]       mode1, mode2, mode3;
    logic [1:0]       addr2, addr3, outsel;
    redundant_poly_L3 dout;

    int n_tests = 0;
    int n_fail  = 0;

    uint_fp_t sb_q [$];
    uint_fp_t m2 [4];
    uint_fp_t m3 [4];

    postadder dut (
        .clk    (clk),
        .rstn   (rstn),
        .in_L1  (din),
        .mode1  (mode1),
        .mode2  (mode2),
        .mode3  (mode3),
        .addr2  (addr2),
        .addr3  (addr3),
        .outsel (outsel),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [303:0] got, input logic [303:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_check(input string tag, input uint_fp_t got);
        uint_fp_t exp;
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 'x;
        check_eq(tag, 304'(got), 304'(exp));
    endtask

    // Integer value of an accumulator word, modulo 2^272
    function automatic uint_fp_t reduce_l3(input redundant_poly_L3 x);
        uint_fp_t acc;
        acc = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            logic signed [L3_W-1:0] l;
            uint_fp_t e;
            l = x[i];
            e = uint_fp_t'(l);
            acc = acc + (e << (LIMB_W * i));
        end
        return acc;
    endfunction

    function automatic uint_fp_t reduce_l1(input redundant_poly_L1 x);
        uint_fp_t acc;
        acc = '0;
        for (int i = 0; i < ADD_DIV; i++) begin
            uint_fp_t e;
            e = uint_fp_t'({x[i].carry, x[i].val});
            acc = acc + (e << (LIMB_W * i));
        end
        return acc;
    endfunction

    function automatic uint_fp_t model_op(input logic [2:0] m, input uint_fp_t d, input uint_fp_t r);
        case (m)
            3'd0:    return r;
            3'd1:    return d;
            3'd2:    return d + r;
            3'd3:    return d - r;
            3'd4:    return r - d;
            3'd5:    return Mod - r;
            3'd6:    return Mod - d;
            default: return '0;
        endcase
    endfunction

    function automatic redundant_poly_L1 mk_l1(input logic [67:0] v);
        redundant_poly_L1 x;
        x = '0;
        x[0].val = v;
        return x;
    endfunction

    function automatic redundant_poly_L1 rand_l1();
        logic [287:0] t;
        for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
        return t[275:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane1_op(input logic [2:0] m, input redundant_poly_L1 d);
        step();
        mode1 = m;
        din   = d;
    endtask

    initial begin
        uint_fp_t d_int;
        uint_fp_t e2, e3;
        uint_fp_t minus5;
        logic [2:0] rm2, rm3;

        rstn = 1'b0; din = rand_l1(); mode1 = 3'd0; mode2 = 3'd0; mode3 = 3'd0;
        addr2 = 2'd0; addr3 = 2'd0; outsel = 2'd0;
        minus5 = '0;
        minus5 = minus5 - 272'd5;

        // Reset: everything reads zero on every outsel
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            outsel = 2'(s);
            #1;
            check_eq($sformatf("rst_dout_sel%0d", s), 304'(dout), 304'd0);
        end
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rst_reg2_%0d", k), 304'(dut.reg2[k]), 304'd0);
            check_eq($sformatf("rst_reg3_%0d", k), 304'(dut.reg3[k]), 304'd0);
        end
        outsel = 2'd0;
        step();
        rstn = 1'b1;
        din  = rand_l1();
        @(negedge clk);
        check_eq("post_rst_acc1", 304'(dut.acc1_out), 304'd0);
        check_eq("post_rst_dout", 304'(dout), 304'd0);

        // Load pass-through
        lane1_op(3'd1, mk_l1(68'h1234));
        @(negedge clk);
        check_eq("din_acc1", 304'(dut.acc1_out), 304'h1234);
        lane1_op(3'd0, rand_l1());
        @(negedge clk);
        check_eq("din_reg1", 304'(dut.reg1), 304'h1234);

        // 127 accumulations of 1
        lane1_op(3'd7, mk_l1(68'd0));
        for (int i = 0; i < 127; i++) lane1_op(3'd2, mk_l1(68'd1));
        lane1_op(3'd0, mk_l1(68'd0));
        @(negedge clk);
        check_eq("acc127_int", 304'(reduce_l3(dut.reg1)), 304'd127);
        check_eq("acc127_limb0", 304'(dut.reg1[0]), 304'd127);

        // Subtract / modulus modes from R=0
        lane1_op(3'd7, mk_l1(68'd0));
        lane1_op(3'd4, mk_l1(68'd5));
        @(negedge clk);
        check_eq("r_minus_din", 304'(reduce_l3(dut.acc1_out)), 304'(minus5));
        lane1_op(3'd7, mk_l1(68'd0));
        lane1_op(3'd5, mk_l1(68'd5));
        @(negedge clk);
        check_eq("mod_minus_r", 304'(reduce_l3(dut.acc1_out)), 304'(Mod));
        lane1_op(3'd1, mk_l1(68'd5));
        lane1_op(3'd3, mk_l1(68'd0));
        @(negedge clk);
        check_eq("din_minus_r", 304'(reduce_l3(dut.acc1_out)), 304'(minus5));

        // Preload every lane-2/3 entry with a distinct value
        mode1 = 3'd0;
        for (int k = 0; k < 4; k++) begin
            step();
            din = rand_l1();
            addr2 = 2'(k); addr3 = 2'(k);
            mode2 = 3'd1;  mode3 = 3'd1;
            m2[k] = reduce_l1(din);
            m3[k] = reduce_l1(din);
        end

        // Random modes on lane 2 entry 1 and lane 3 entry 2
        for (int c = 0; c < 40; c++) begin
            step();
            din   = rand_l1();
            rm2   = 3'($urandom_range(0, 7));
            rm3   = 3'($urandom_range(0, 7));
            addr2 = 2'd1; addr3 = 2'd2;
            mode2 = rm2;  mode3 = rm3;
            d_int = reduce_l1(din);
            e2 = model_op(rm2, d_int, m2[1]);
            e3 = model_op(rm3, d_int, m3[2]);
            sb_q.push_back(e2);
            sb_q.push_back(e3);
            m2[1] = e2;
            m3[2] = e3;
            @(negedge clk);
            sb_check($sformatf("rnd%0d_acc2", c), reduce_l3(dut.acc2_out));
            sb_check($sformatf("rnd%0d_acc3", c), reduce_l3(dut.acc3_out));
        end
        step();
        mode2 = 3'd0; mode3 = 3'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("hold_reg2_%0d", k), 304'(reduce_l3(dut.reg2[k])), 304'(m2[k]));
            check_eq($sformatf("hold_reg3_%0d", k), 304'(reduce_l3(dut.reg3[k])), 304'(m3[k]));
        end

        // Output select sweep with distinct lane results
        step();
        din = rand_l1();
        mode1 = 3'd1; mode2 = 3'd0; mode3 = 3'd6;
        d_int = reduce_l1(din);
        sb_q.push_back(d_int);
        sb_q.push_back(m2[1]);
        sb_q.push_back(Mod - d_int);
        sb_q.push_back('0);
        for (int s = 0; s < 4; s++) begin
            outsel = 2'(s);
            #1;
            sb_check($sformatf("outsel%0d", s), reduce_l3(dout));
        end
        check_eq("sb_drained", 304'(sb_q.size()), 304'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
